// File: rtl/risc_core_mc.sv
// risc_core_mc -- small multi-cycle 8-bit-instruction RISC core.
//
// Each instruction takes a FETCH phase, which waits for imem_ack, and a
// single EXEC cycle. The EXEC cycle does the register write and updates pc.
// The register file is 4 x DW. Register r0 is an ordinary register and is
// writable.
//
// Ports:
//   clk        in   clock; all state changes on the rising edge
//   reset      in   asynchronous, active-high reset
//   run        in   leave IDLE and start fetching
//   imem_req   out  fetch request (registered), high only in FETCH
//   imem_addr  out  fetch address, always equal to pc
//   imem_ack   in   imem_data is valid this cycle (only looked at in FETCH)
//   imem_data  in   8-bit instruction
//   wb_valid   out  one-cycle pulse after an ADD/ADDI writeback
//   result     out  value written by the most recent writeback
//   halted     out  core has executed HALT
//   pc_out     out  current pc
//   dbg_rsel   in   debug register select
//   dbg_rdata  out  combinational read of r[dbg_rsel]
module risc_core_mc #(
  parameter int DW  = 8,
  parameter int PCW = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           run,
  output logic           imem_req,
  output logic [PCW-1:0] imem_addr,
  input  logic           imem_ack,
  input  logic [7:0]     imem_data,
  output logic           wb_valid,
  output logic [DW-1:0]  result,
  output logic           halted,
  output logic [PCW-1:0] pc_out,
  input  logic [1:0]     dbg_rsel,
  output logic [DW-1:0]  dbg_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]     state;
  logic [PCW-1:0] pc;
  logic [7:0]     ir;
  logic [DW-1:0]  rf [0:3];

  logic [DW-1:0]  src_a;
  logic [DW-1:0]  add_b;
  logic [DW-1:0]  alu_sum;
  logic [PCW-1:0] pc_inc;
  logic [PCW-1:0] beq_off;
  logic [PCW-1:0] jmpr_off;
  logic [PCW-1:0] pc_next;
  logic           br_taken;
  logic           is_wb;
  logic           is_halt;

  // Decode and execute the held instruction. All reads come from the
  // register file as it was before this EXEC edge, so a destination that is
  // also a source reads its old value.
  always_comb begin
    src_a    = rf[ir[3:2]];
    // ir[6] separates ADDI (zero-extended immediate) from ADD (register).
    add_b    = ir[6] ? DW'(ir[1:0]) : rf[ir[1:0]];
    alu_sum  = src_a + add_b;
    pc_inc   = pc + PCW'(1);
    beq_off  = PCW'($signed(ir[2:0]));
    jmpr_off = PCW'($signed(ir[3:0]));
    br_taken = (rf[ir[5:4]] == rf[{1'b0, ir[3]}]);
    is_wb    = ~ir[7];
    is_halt  = ir[7] & ir[6] & ir[5];
    pc_next  = pc_inc;
    case (ir[7:6])
      2'b10: begin
        if (br_taken) pc_next = pc_inc + beq_off;
      end
      2'b11: begin
        if (ir[5])      pc_next = pc;
        else if (ir[4]) pc_next = pc_inc + jmpr_off;
        else            pc_next = PCW'(ir[3:0]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      pc       <= '0;
      ir       <= '0;
      imem_req <= 1'b0;
      wb_valid <= 1'b0;
      result   <= '0;
      halted   <= 1'b0;
      for (int i = 0; i < 4; i++) rf[i] <= '0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (run) begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
          end
        end
        S_FETCH: begin
          // Request and address stay put until the acknowledging edge.
          if (imem_ack) begin
            ir       <= imem_data;
            state    <= S_EXEC;
            imem_req <= 1'b0;
          end
        end
        S_EXEC: begin
          pc <= pc_next;
          if (is_wb) begin
            rf[ir[5:4]] <= alu_sum;
            result      <= alu_sum;
            wb_valid    <= 1'b1;
          end
          if (is_halt) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
          end
        end
        default: ; // S_HALT: only reset leaves this state
      endcase
    end
  end

  assign imem_addr = pc;
  assign pc_out    = pc;
  assign dbg_rdata = rf[dbg_rsel];

endmodule

// File: tb/tb_risc_core_mc.sv
// tb_risc_core_mc -- self-checking bench for risc_core_mc.
//
// The bench plays instruction memory from an array. Each time it
// acknowledges a fetch, it executes that instruction in a reference model.
// For ADD/ADDI the model pushes the expected writeback value onto a queue,
// and the queue is popped whenever wb_valid is seen. A second instance with
// PCW=4 covers the pc wrap-around case.
module tb_risc_core_mc;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, run, imem_ack, imem_req, wb_valid, halted;
  logic [7:0] imem_data, imem_addr, result, pc_out, dbg_rdata;
  logic [1:0] dbg_rsel;

  logic       run4, ack4, req4, wb4, halted4;
  logic [7:0] data4, result4, dbg4_rdata;
  logic [3:0] addr4, pc4;
  logic [1:0] dbg4_sel;

  risc_core_mc #(.DW(8), .PCW(8)) u_dut (
    .clk(clk), .reset(reset), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .wb_valid(wb_valid), .result(result),
    .halted(halted), .pc_out(pc_out), .dbg_rsel(dbg_rsel), .dbg_rdata(dbg_rdata)
  );

  risc_core_mc #(.DW(8), .PCW(4)) u_dut4 (
    .clk(clk), .reset(reset), .run(run4),
    .imem_req(req4), .imem_addr(addr4), .imem_ack(ack4),
    .imem_data(data4), .wb_valid(wb4), .result(result4),
    .halted(halted4), .pc_out(pc4), .dbg_rsel(dbg4_sel), .dbg_rdata(dbg4_rdata)
  );

  int         checks = 0;
  int         failures = 0;
  int         wb_seen;
  logic [7:0] mem [0:255];
  logic [7:0] m_r [0:3];
  logic [7:0] m_pc;
  bit         m_halt;
  logic [7:0] exp_q [$];

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'hE0; // HALT everywhere by default
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 8'd0;
    m_pc = 8'd0;
    m_halt = 1'b0;
    wb_seen = 0;
    exp_q.delete();
  endtask

  task automatic model_exec(input logic [7:0] ins);
    logic [7:0] v;
    case (ins[7:6])
      2'b00, 2'b01: begin
        v = m_r[ins[3:2]] + (ins[6] ? {6'd0, ins[1:0]} : m_r[ins[1:0]]);
        m_r[ins[5:4]] = v;
        exp_q.push_back(v);
        m_pc = m_pc + 8'd1;
      end
      2'b10: begin
        if (m_r[ins[5:4]] == m_r[{1'b0, ins[3]}])
          m_pc = m_pc + 8'd1 + {{5{ins[2]}}, ins[2:0]};
        else
          m_pc = m_pc + 8'd1;
      end
      default: begin
        if (ins[5])      m_halt = 1'b1;
        else if (ins[4]) m_pc = m_pc + 8'd1 + {{4{ins[3]}}, ins[3:0]};
        else             m_pc = {4'd0, ins[3:0]};
      end
    endcase
  endtask

  task automatic check_regs(input string tag);
    for (int k = 0; k < 4; k++) begin
      dbg_rsel = k[1:0];
      #1;
      checks++;
      if (dbg_rdata !== m_r[k]) begin
        failures++;
        $display("FAIL %s_r%0d: got %0d expected %0d", tag, k, dbg_rdata, m_r[k]);
      end
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1; run = 1'b0; imem_ack = 1'b0; run4 = 1'b0; ack4 = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  // Serve fetches from mem[] with ws wait cycles per fetch, and check every
  // fetch address and every writeback until the core halts or the budget
  // runs out.
  task automatic run_core(input int budget, input int ws, input bit expect_halt,
                          output int cycles);
    int waitcnt = 0;
    bit started = 0;
    bit pend = 0;
    bit done = 0;
    logic [7:0] exp;
    cycles = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk); #1;
      imem_ack = 1'b0;
      if (wb_valid) begin
        wb_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL wb_unexpected: wb_valid=1 result=%0d, expected no writeback", result);
        end else begin
          exp = exp_q.pop_front();
          if (result !== exp) begin
            failures++;
            $display("FAIL wb_result: got %0d expected %0d", result, exp);
          end
        end
      end
      if (halted) begin
        checks++;
        if (!m_halt) begin
          failures++;
          $display("FAIL halted_early: halted=1 at pc=%0d, expected 0", pc_out);
        end
        done = 1;
      end else begin
        if (pend) begin
          checks++;
          if (imem_req !== 1'b1) begin
            failures++;
            $display("FAIL req_dropped: imem_req=%b expected 1 during wait", imem_req);
          end
        end
        pend = 0;
        if (imem_req === 1'b1) started = 1;
        if (started) cycles++;
        if (imem_req === 1'b1) begin
          checks++;
          if (imem_addr !== m_pc || pc_out !== m_pc || m_halt) begin
            failures++;
            $display("FAIL fetch_addr: addr=%0d pc_out=%0d expected %0d (model halted=%0d)",
                     imem_addr, pc_out, m_pc, m_halt);
          end
          if (waitcnt < ws) begin
            waitcnt++;
            pend = 1;
          end else begin
            waitcnt = 0;
            imem_ack = 1'b1;
            imem_data = mem[imem_addr];
            model_exec(imem_data);
          end
        end
      end
    end
    imem_ack = 1'b0;
    if (expect_halt && !done) begin
      checks++; failures++;
      $display("FAIL timeout: no halt within %0d cycles, halted=%b expected 1", budget, halted);
    end
  endtask

  task automatic load_sum();
    clear_mem();
    mem[0] = 8'b01000011; mem[1] = 8'b01000011; mem[2] = 8'b01000011;
    mem[3] = 8'b01000001; mem[4] = 8'b01010100; mem[5] = 8'b01101000;
    mem[6] = 8'b10001011; mem[7] = 8'b00101001; mem[8] = 8'b01010101;
    mem[9] = 8'b11000110; mem[10] = 8'b11100000;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; imem_ack = 1'b0; imem_data = 8'd0; dbg_rsel = 2'd0;
    run4 = 1'b0; ack4 = 1'b0; data4 = 8'd0; dbg4_sel = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req: got %b expected 0", imem_req); end
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL rst_wb: got %b expected 0", wb_valid); end
    checks++; if (result !== 8'd0) begin failures++; $display("FAIL rst_result: got %0d expected 0", result); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rst_halted: got %b expected 0", halted); end
    checks++; if (pc_out !== 8'd0) begin failures++; $display("FAIL rst_pc: got %0d expected 0", pc_out); end
    check_regs("rst");
    reset = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      checks++;
      if (imem_req !== 1'b0) begin failures++; $display("FAIL idle_no_fetch: imem_req=%b expected 0", imem_req); end
    end
  endtask

  task automatic test_sum();
    int cycles;
    load_sum();
    run = 1'b1;
    run_core(400, 0, 1'b1, cycles);
    checks++; if (cycles != 96) begin failures++; $display("FAIL sum_cycles: got %0d expected 96", cycles); end
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL sum_halted: got %b expected 1", halted); end
    dbg_rsel = 2'd0; #1;
    checks++; if (dbg_rdata !== 8'd10) begin failures++; $display("FAIL sum_r0: got %0d expected 10", dbg_rdata); end
    dbg_rsel = 2'd2; #1;
    checks++; if (dbg_rdata !== 8'd45) begin failures++; $display("FAIL sum_r2: got %0d expected 45", dbg_rdata); end
    check_regs("sum");
  endtask

  task automatic test_halt_hold();
    imem_ack = 1'b1; run = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      checks++;
      if (imem_req !== 1'b0 || halted !== 1'b1) begin
        failures++;
        $display("FAIL halt_hold: imem_req=%b halted=%b expected 0/1", imem_req, halted);
      end
    end
    imem_ack = 1'b0;
    reset = 1'b1; #1;
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL halt_reset: halted=%b expected 0", halted); end
    @(posedge clk); #1 reset = 1'b0; run = 1'b0;
    model_reset();
  endtask

  task automatic test_wait_states();
    int cycles;
    apply_reset();
    clear_mem();
    mem[0] = 8'b01010111; // ADDI r1,r1,3
    mem[1] = 8'b00100101; // ADD  r2,r1,r1
    run = 1'b1;
    run_core(100, 3, 1'b1, cycles);
    checks++; if (cycles != 15) begin failures++; $display("FAIL ws_cycles: got %0d expected 15", cycles); end
    check_regs("ws");
  endtask

  task automatic test_mid_fetch_reset();
    int cycles;
    apply_reset();
    load_sum();
    run = 1'b1;
    run_core(30, 0, 1'b0, cycles);
    for (int k = 0; k < 4 && imem_req !== 1'b1; k++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (imem_req !== 1'b1) begin failures++; $display("FAIL midrst_pre: imem_req=%b expected 1", imem_req); end
    dbg_rsel = 2'd0; #1;
    checks++; if (dbg_rdata !== 8'd10) begin failures++; $display("FAIL midrst_r0_pre: got %0d expected 10", dbg_rdata); end
    #1 reset = 1'b1;
    #1;
    model_reset();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL midrst_req: got %b expected 0", imem_req); end
    checks++; if (pc_out !== 8'd0) begin failures++; $display("FAIL midrst_pc: got %0d expected 0", pc_out); end
    check_regs("midrst");
    @(posedge clk); #1 reset = 1'b0; run = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (imem_req !== 1'b0) begin failures++; $display("FAIL midrst_idle: imem_req=%b expected 0", imem_req); end
    end
  endtask

  task automatic test_wrap_reg();
    int cycles;
    apply_reset();
    clear_mem();
    mem[0] = 8'b01000001;                 // r0 = 1
    for (int k = 0; k < 7; k++) begin     // r0 = 2*r0 + 1, up to 255
      mem[1 + 2*k] = 8'b00000000;
      mem[2 + 2*k] = 8'b01000001;
    end
    mem[15] = 8'b01000001;                // 255 + 1 wraps to 0
    run = 1'b1;
    run_core(200, 0, 1'b1, cycles);
    checks++; if (result !== 8'd0) begin failures++; $display("FAIL wrap_result: got %0d expected 0", result); end
    checks++; if (wb_seen != 16) begin failures++; $display("FAIL wrap_wbcount: got %0d expected 16", wb_seen); end
    dbg_rsel = 2'd0; #1;
    checks++; if (dbg_rdata !== 8'd0) begin failures++; $display("FAIL wrap_r0: got %0d expected 0", dbg_rdata); end
  endtask

  task automatic test_branch();
    int cycles;
    // Registers equal: BEQ at 5 with offset -4 goes to 2, then JMPR +3 to 6.
    apply_reset();
    clear_mem();
    mem[0] = 8'b11000101; mem[5] = 8'b10000100; mem[2] = 8'b11010011;
    run = 1'b1;
    run_core(100, 0, 1'b1, cycles);
    checks++; if (pc_out !== 8'd6) begin failures++; $display("FAIL beq_eq_pc: got %0d expected 6", pc_out); end
    checks++; if (wb_seen != 0) begin failures++; $display("FAIL beq_eq_wb: got %0d pulses expected 0", wb_seen); end
    // Registers unequal: BEQ falls through to 6.
    apply_reset();
    clear_mem();
    mem[0] = 8'b01010101; mem[1] = 8'b11000101; mem[5] = 8'b10001100;
    run = 1'b1;
    run_core(100, 0, 1'b1, cycles);
    checks++; if (pc_out !== 8'd6) begin failures++; $display("FAIL beq_ne_pc: got %0d expected 6", pc_out); end
    checks++; if (wb_seen != 1) begin failures++; $display("FAIL beq_ne_wb: got %0d pulses expected 1", wb_seen); end
  endtask

  task automatic test_wrap_pc();
    logic [3:0] addrs [0:2];
    int n = 0;
    apply_reset();
    run4 = 1'b1;
    for (int i = 0; i < 30 && n < 3; i++) begin
      @(posedge clk); #1;
      ack4 = 1'b0;
      if (req4 === 1'b1) begin
        addrs[n] = addr4;
        n++;
        ack4 = 1'b1;
        data4 = (addr4 == 4'd0) ? 8'b11001111 : 8'b01000001; // JMP 15 / ADDI r0,r0,1
      end
    end
    @(posedge clk); #1 ack4 = 1'b0; run4 = 1'b0;
    checks++;
    if (n != 3) begin
      failures++; $display("FAIL pcw4_timeout: got %0d fetches expected 3", n);
    end else begin
      checks++;
      if (addrs[0] !== 4'd0 || addrs[1] !== 4'd15 || addrs[2] !== 4'd0) begin
        failures++;
        $display("FAIL pcw4_addrs: got %0d,%0d,%0d expected 0,15,0", addrs[0], addrs[1], addrs[2]);
      end
    end
    dbg4_sel = 2'd0; #1;
    checks++; if (dbg4_rdata !== 8'd1) begin failures++; $display("FAIL pcw4_r0: got %0d expected 1", dbg4_rdata); end
  endtask

  initial begin
    test_reset();
    test_sum();
    test_halt_hold();
    test_wait_states();
    test_mid_fetch_reset();
    test_wrap_reg();
    test_branch();
    test_wrap_pc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/risc_core_mc.md
RISC_CORE_MC -- requirements
Module: risc_core_mc

Interface
REQ-001 Parameter DW, default 8, register and ALU data width (min 4).
REQ-002 Parameter PCW, default 8, program counter and instruction-address width (min 4).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 run  input  1  start fetching from IDLE.
REQ-006 imem_req  output  1  fetch request, registered.
REQ-007 imem_addr  output  PCW  fetch address, equals pc.
REQ-008 imem_ack  input  1  fetch data valid this cycle.
REQ-009 imem_data  input  8  fetched instruction.
REQ-010 wb_valid  output  1  one-cycle pulse on register writeback.
REQ-011 result  output  DW  value written at the last writeback.
REQ-012 halted  output  1  core is in HALT.
REQ-013 pc_out  output  PCW  current pc.
REQ-014 dbg_rsel  input  2  debug register select.
REQ-015 dbg_rdata  output  DW  combinational read of r[dbg_rsel].

Function
REQ-016 Register file: 4 x DW registers r0..r3; r0 writable (not hardwired); at most one write per instruction.
REQ-017 FSM states: IDLE, FETCH, EXEC, HALT.
REQ-018 Transitions: IDLE->FETCH when run=1; FETCH->EXEC on the edge where imem_ack=1; EXEC->FETCH, or EXEC->HALT for HALT opcode; HALT exits only via reset.
REQ-019 In FETCH, imem_req=1 and imem_addr=pc, both stable until imem_ack sampled high; on that edge ir<=imem_data.
REQ-020 imem_req=0 in IDLE, EXEC and HALT; imem_ack is ignored outside FETCH.
REQ-021 EXEC lasts exactly one cycle; it performs the register write and the pc update. Minimum 2 cycles per instruction.
REQ-022 ADD (ir[7:6]=00): r[ir[5:4]] <= r[ir[3:2]] + r[ir[1:0]], mod 2^DW; pc <= pc+1.
REQ-023 ADDI (01): r[ir[5:4]] <= r[ir[3:2]] + zero-extended ir[1:0], mod 2^DW; pc <= pc+1.
REQ-024 BEQ (10): compare r[ir[5:4]] with r[{0,ir[3]}]. If equal, pc <= pc+1+sext(ir[2:0]) (range -4..+3); otherwise pc <= pc+1. No register write.
REQ-025 JMP (11, ir[5:4]=00): pc <= zero-extended ir[3:0].
REQ-026 JMPR (11, ir[5:4]=01): pc <= pc+1+sext(ir[3:0]).
REQ-027 HALT (11, ir[5]=1): pc unchanged; halted=1 from the next cycle.
REQ-028 All pc arithmetic is mod 2^PCW; wrap-around is silent.
REQ-029 Register reads in EXEC see pre-write values, including when the destination equals a source.
REQ-030 wb_valid=1 for exactly the cycle after an ADD/ADDI EXEC edge, and result updates on that same edge. Branch, jump and HALT leave wb_valid=0 and result unchanged.
REQ-031 pc_out equals pc at all times.

Reset
REQ-032 Reset asynchronously forces state=IDLE, pc=0, ir=0, r0..r3=0, imem_req=0, wb_valid=0, result=0, halted=0.
REQ-033 Reset asserted mid-FETCH or mid-EXEC abandons the instruction with no register write.
REQ-034 After reset deasserts, no fetch occurs until run=1.

Verification
REQ-035 Sum program, DW=8, imem_ack tied 1, run=1: 0-3: 01000011 x3, 01000001; 4: 01010100; 5: 01101000; 6: 10001011; 7: 00101001; 8: 01010101; 9: 11000110; 10: 11100000 -> r0=10, r2=45, halted=1 after exactly 48 instructions (96 EXEC/FETCH cycles from first FETCH).
REQ-036 Wait states: imem_ack held low 3 cycles -> imem_req=1 and imem_addr constant for 4 cycles; no register or pc change until the ack edge.
REQ-037 Wrap: r0=255, ADDI r0,r0,1 -> r0=0, wb_valid pulse, result=0. PCW=4, non-branch at pc=15 -> next fetch address 0.
REQ-038 Branch: BEQ at pc=5 with off=100, registers equal -> pc=2. Same instruction with registers unequal -> pc=6. Neither case pulses wb_valid.
REQ-039 Reset mid-FETCH (imem_req=1) -> imem_req, pc and all registers 0 in the same cycle, without waiting for a clock edge; state IDLE.
REQ-040 HALT -> halted=1, imem_req stays 0 for 20 cycles despite imem_ack=1 and run=1; reset clears halted.
